receive: RTL and testbench
==========================

Name: receive

Overview:
- UART/SPART receive stage; the counterpart of the transmit stage on the far end of the serial link.
- Samples rxd using a baud-enable strobe running at OVERSAMPLE x the bit rate, and deframes 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Holds the received byte for the bus interface with a ready flag (rda) and error flags.

Parameters:
OVERSAMPLE, 16, receive_baud strobes per bit period; power of 2, >= 4.

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
receive_baud  input  1  one-clk strobe, OVERSAMPLE per bit time
rxd  input  1  asynchronous serial input; idles high
receive_read_en  input  1  bus read strobe; consumes the held byte
receive_read_line  output  8  last received byte
rda  output  1  receive data available
framing_err  output  1  stop bit sampled low on the held byte
overrun_err  output  1  a byte completed while rda was still 1
receive_start  output  1  one-clk pulse when a start bit is validated

Behaviour:
- Reset is asynchronous and active-low; all flops clear.
  - Outputs at reset: receive_read_line=8'h00, rda=0, framing_err=0, overrun_err=0, receive_start=0.
  - Synchronizer flops reset to 1; state resets to IDLE.
- rxd passes through a 2-flop synchronizer (rxd_s). All sampling uses rxd_s.
- samp_cnt is a $clog2(OVERSAMPLE)-bit counter. It increments only on receive_baud and wraps naturally.
- MID = OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: if rxd_s==0, clear samp_cnt -> START.
  - START: when receive_baud and samp_cnt==MID-1:
    - rxd_s==0: pulse receive_start, clear samp_cnt and bit_cnt -> DATA.
    - otherwise: glitch; -> IDLE with no flag change.
  - DATA: when receive_baud and samp_cnt==OVERSAMPLE-1 (mid-bit):
    - shift {rxd_s, shreg[7:1]} into the 8-bit shift register.
    - increment bit_cnt (3 bits).
    - on the 8th sample (bit_cnt==7) -> STOP.
  - STOP: when receive_baud and samp_cnt==OVERSAMPLE-1, the frame completes:
    - load receive_read_line <= shreg and set rda=1.
    - framing_err <= ~rxd_s.
    - overrun_err <= rda_old & ~receive_read_en (rda_old is rda before this update).
    - next state: WAIT_IDLE if rxd_s==0, else IDLE.
  - WAIT_IDLE: stay until rxd_s==1 (break/stuck-low line), then -> IDLE. No new frame can start from here.
- Latency:
  - rda rises on the clk edge that acts on the mid-stop-bit baud strobe.
  - From the rxd falling edge to rda is about 9.5 bit times plus 2-3 clks of synchronizer delay.
- Read rules:
  - receive_read_en clears rda, framing_err and overrun_err on the next edge.
  - receive_read_line holds its value until the next frame completes; reading never alters it.
  - receive_read_en while rda==0: no effect.
- Simultaneous frame completion and receive_read_en:
  - The completion wins: rda stays 1, new data is loaded, framing_err reflects the new frame, overrun_err=0.
- Overrun: the new byte overwrites the held byte. overrun_err stays set until read.
- Any tick without receive_baud holds all counters. receive_baud asserted on every clk is legal.
- Reset mid-frame: returns immediately to IDLE with flags cleared. The partial byte is discarded.

Decomposition:
- Shared package spart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Constants SPART_DATA_BITS=8 and SPART_OVERSAMPLE=16.
  - The transmit stage imports the same data-width constant.
- One sub-module, sync2: a 2-flop synchronizer with reset value parameter RST_VAL=1. Reusable elsewhere for CTS/async inputs.
- Counters, shift register and FSM remain inline.

Test Plan:
- Frame 0xA5 (rxd: 0, 1,0,1,0,0,1,0,1, 1) at OVERSAMPLE=16, receive_baud every 4 clks -> receive_start pulses once; rda=1, receive_read_line=8'hA5, framing_err=0, overrun_err=0; after receive_read_en, rda=0 and the line is still 8'hA5.
- Glitch: rxd low for 5 baud ticks then high -> no receive_start, rda stays 0, FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0x3C with stop bit = 0, rxd held low 2 more bit times -> rda=1, data 8'h3C, framing_err=1; no second frame starts until rxd returns high.
- Back-to-back frames 0x11 then 0x22 with no read -> after the second: receive_read_line=8'h22, rda=1, overrun_err=1; one read clears all three flags.
- Read asserted on the exact completion cycle of 0x77 while holding unread 0x66 -> rda=1, data 8'h77, overrun_err=0.
- rst_n pulsed low during DATA bit 4 of 0xF0 -> all outputs return to reset values asynchronously; the next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/spart_pkg.sv
// ============================================================================
// Module : spart_pkg
// Brief  : Shared SPART types and constants for the transmit and receive stages.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spart_pkg;

  localparam int SPART_DATA_BITS  = 8;
  localparam int SPART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop synchronizer for asynchronous single-bit inputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/receive.sv
// ============================================================================
// Module : receive
// Brief  : SPART 8N1 receive stage with oversampled start validation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module receive
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       receive_baud,
  input  logic                       rxd,
  input  logic                       receive_read_en,
  output logic [SPART_DATA_BITS-1:0] receive_read_line,
  output logic                       rda,
  output logic                       framing_err,
  output logic                       overrun_err,
  output logic                       receive_start
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(SPART_DATA_BITS);
  localparam logic [SW-1:0] MID_M1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SPART_DATA_BITS - 1);

  logic                       rxd_s;
  rx_state_t                  state_q;
  logic [SW-1:0]              samp_cnt_q;
  logic [BW-1:0]              bit_cnt_q;
  logic [SPART_DATA_BITS-1:0] shreg_q;
  logic                       w_mid_bit;

  sync2 #(.RST_VAL(1'b1)) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  // After start validation the counter is re-zeroed at mid-bit, so each wrap lands mid-bit.
  assign w_mid_bit = receive_baud && (samp_cnt_q == SAMP_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      samp_cnt_q        <= '0;
      bit_cnt_q         <= '0;
      shreg_q           <= '0;
      receive_read_line <= '0;
      rda               <= 1'b0;
      framing_err       <= 1'b0;
      overrun_err       <= 1'b0;
      receive_start     <= 1'b0;
    end else begin
      receive_start <= 1'b0;
      if (receive_baud) begin
        samp_cnt_q <= samp_cnt_q + 1'b1;
      end
      if (receive_read_en) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            samp_cnt_q <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (receive_baud && (samp_cnt_q == MID_M1)) begin
            if (!rxd_s) begin
              receive_start <= 1'b1;
              samp_cnt_q    <= '0;
              bit_cnt_q     <= '0;
              state_q       <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_mid_bit) begin
            shreg_q   <= {rxd_s, shreg_q[SPART_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          // Frame completion overrides a coincident read.
          if (w_mid_bit) begin
            receive_read_line <= shreg_q;
            rda               <= 1'b1;
            framing_err       <= ~rxd_s;
            overrun_err       <= rda & ~receive_read_en;
            state_q           <= rxd_s ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_receive.sv
// ============================================================================
// Module : tb_receive
// Brief  : Self-checking bench for the SPART receive stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_receive;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       receive_baud = 1'b0;
  logic       rxd = 1'b1;
  logic       receive_read_en = 1'b0;
  logic [7:0] receive_read_line;
  logic       rda;
  logic       framing_err;
  logic       overrun_err;
  logic       receive_start;

  int errors = 0;
  int checks = 0;
  int div = 4;
  int start_cnt = 0;

  // Expected bus-visible state
  logic [7:0] exp_data = 8'h00;
  logic       exp_rda = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_oe = 1'b0;

  receive #(.OVERSAMPLE(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .receive_baud      (receive_baud),
    .rxd               (rxd),
    .receive_read_en   (receive_read_en),
    .receive_read_line (receive_read_line),
    .rda               (rda),
    .framing_err       (framing_err),
    .overrun_err       (overrun_err),
    .receive_start     (receive_start)
  );

  always #5 clk = ~clk;

  initial begin : baud_gen
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (n >= div) begin
        n = 0;
        receive_baud = 1'b1;
      end else begin
        receive_baud = 1'b0;
      end
    end
  end

  always @(negedge clk) if (receive_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".rda"}, {31'd0, rda}, {31'd0, exp_rda});
    chk({tag, ".data"}, {24'd0, receive_read_line}, {24'd0, exp_data});
    chk({tag, ".fe"}, {31'd0, framing_err}, {31'd0, exp_fe});
    chk({tag, ".oe"}, {31'd0, overrun_err}, {31'd0, exp_oe});
  endtask

  task automatic wait_bauds(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (receive_baud) k++;
    end
  endtask

  task automatic do_read();
    @(negedge clk);
    receive_read_en = 1'b1;
    @(negedge clk);
    receive_read_en = 1'b0;
    exp_rda = 1'b0;
    exp_fe  = 1'b0;
    exp_oe  = 1'b0;
  endtask

  // Drives one 8N1 frame at 16 baud ticks per bit. rd_at_done raises the read strobe
  // on the completion edge: 2 sync flops plus the IDLE edge, then 8 + 8*16 + 16 ticks.
  // abort_nb > 0 pulses reset after that many ticks of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_at_done,
                            input int abort_nb);
    logic [9:0] bits;
    int nb, ne, nd;
    bits = {stop, b, 1'b0};
    nb = 0; ne = 0; nd = 0;
    @(negedge clk);
    rxd = 1'b0;
    while (nb < 160) begin
      @(posedge clk);
      ne++;
      if (receive_baud) begin
        nb++;
        if (ne > 3) nd++;
      end
      @(negedge clk);
      if (abort_nb > 0 && nb == abort_nb) begin
        rst_n = 1'b0;
        #1;
        exp_rda = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0; exp_data = 8'h00;
        check_state("mid_reset");
        chk("mid_reset.start", {31'd0, receive_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rxd = 1'b1;
        return;
      end
      rxd = (nb < 160) ? bits[nb / 16] : stop;
      receive_read_en = rd_at_done && (ne >= 3) && receive_baud && (nd == 151);
    end
    receive_read_en = 1'b0;
    exp_oe   = exp_rda && !rd_at_done;
    exp_rda  = 1'b1;
    exp_data = b;
    exp_fe   = !stop;
  endtask

  initial begin : main
    int s0;
    logic [7:0] rb;
    logic rs;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.start", {31'd0, receive_start}, 32'd0);
    rst_n = 1'b1;
    wait_bauds(4);

    // Basic frame
    div = 4;
    s0 = start_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    check_state("a5");
    chk("a5.start_pulses", start_cnt - s0, 32'd1);
    do_read();
    check_state("a5_read");

    // Glitch shorter than half a bit
    s0 = start_cnt;
    @(negedge clk);
    rxd = 1'b0;
    wait_bauds(5);
    @(negedge clk);
    rxd = 1'b1;
    wait_bauds(20);
    chk("glitch.start_pulses", start_cnt - s0, 32'd0);
    check_state("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    check_state("after_glitch");
    do_read();

    // Framing error with line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check_state("framing");
    s0 = start_cnt;
    wait_bauds(32);
    chk("break.start_pulses", start_cnt - s0, 32'd0);
    @(negedge clk);
    rxd = 1'b1;
    wait_bauds(4);
    do_read();
    check_state("framing_read");

    // Overrun
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    check_state("overrun");
    do_read();
    check_state("overrun_read");

    // Read coincident with completion
    send_frame(8'h66, 1'b1, 1'b0, 0);
    check_state("hold66");
    send_frame(8'h77, 1'b1, 1'b1, 0);
    check_state("coincident");

    // Reset during data bit 4, then a clean frame
    send_frame(8'hF0, 1'b1, 1'b0, 16 * 5 + 8);
    wait_bauds(4);
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    check_state("post_reset");

    // Randomized frames at varied baud rates
    for (int i = 0; i < 8; i++) begin
      div = int'($urandom_range(1, 6));
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) do_read();
      wait_bauds(2);
      send_frame(rb, rs, 1'b0, 0);
      check_state("rnd");
      if (!rs) begin
        @(negedge clk);
        rxd = 1'b1;
        wait_bauds(4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
